// File: rtl/character_renderer.sv
// Sprite erase/redraw stage in front of the VGA adapter: each accepted frame
// erases the sprite at its last drawn position, then draws it at the new one.
module character_renderer #(
  parameter int unsigned SPRITE_W  = 4,
  parameter int unsigned SPRITE_H  = 4,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       iNewFrame,
  input  logic [7:0] iXcoord,
  input  logic [6:0] iYcoord,
  input  logic [2:0] iColour,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot,
  output logic       oBusy,
  output logic       oDone,
  output logic       oOverrun
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_e;

  localparam logic [3:0] LAST_DX  = 4'(SPRITE_W - 1);
  localparam logic [3:0] LAST_DY  = 4'(SPRITE_H - 1);
  localparam logic [8:0] LIMIT_X  = 9'(SCREEN_W);
  localparam logic [7:0] LIMIT_Y  = 8'(SCREEN_H);

  state_e     state_q, state_d;
  logic [3:0] dx_q, dx_d, dy_q, dy_d;
  logic [7:0] new_x_q, new_x_d, old_x_q, old_x_d;
  logic [6:0] new_y_q, new_y_d, old_y_q, old_y_d;
  logic [2:0] new_col_q, new_col_d, old_col_q, old_col_d;
  logic       drawn_q, drawn_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;

  logic       pix_active;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  always_comb begin
    state_d   = state_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    new_x_d   = new_x_q;
    new_y_d   = new_y_q;
    new_col_d = new_col_q;
    old_x_d   = old_x_q;
    old_y_d   = old_y_q;
    old_col_d = old_col_q;
    drawn_d   = drawn_q;

    case (state_q)
      IDLE: begin
        if (iNewFrame) begin
          new_x_d   = iXcoord;
          new_y_d   = iYcoord;
          new_col_d = iColour;
          dx_d      = '0;
          dy_d      = '0;
          if (!drawn_q) begin
            state_d = DRAW;
          end else if (iXcoord == old_x_q && iYcoord == old_y_q && iColour == old_col_q) begin
            state_d = FINISH;
          end else begin
            state_d = ERASE;
          end
        end
      end
      ERASE, DRAW: begin
        if (dx_q == LAST_DX) begin
          dx_d = '0;
          if (dy_q == LAST_DY) begin
            dy_d = '0;
            if (state_q == ERASE) state_d = DRAW;
            else                  state_d = FINISH;
          end else begin
            dy_d = dy_q + 4'd1;
          end
        end else begin
          dx_d = dx_q + 4'd1;
        end
      end
      FINISH: begin
        old_x_d   = new_x_q;
        old_y_d   = new_y_q;
        old_col_d = new_col_q;
        drawn_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pixel outputs are derived from the next walk position so the first
    // pixel is on the wire the cycle right after the accepting edge.
    pix_active = (state_d == ERASE) || (state_d == DRAW);
    base_x     = (state_d == ERASE) ? old_x_q : new_x_d;
    base_y     = (state_d == ERASE) ? old_y_q : new_y_d;
    sum_x      = {1'b0, base_x} + {5'b0, dx_d};
    sum_y      = {1'b0, base_y} + {4'b0, dy_d};

    plot_d    = pix_active && (sum_x < LIMIT_X) && (sum_y < LIMIT_Y);
    x_d       = pix_active ? sum_x[7:0] : '0;
    y_d       = pix_active ? sum_y[6:0] : '0;
    colour_d  = !pix_active ? '0 : (state_d == ERASE) ? BG_COLOUR : new_col_d;
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == FINISH);
    overrun_d = iNewFrame && (state_q != IDLE);
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_q   <= IDLE;
      dx_q      <= '0;
      dy_q      <= '0;
      new_x_q   <= '0;
      new_y_q   <= '0;
      new_col_q <= '0;
      old_x_q   <= '0;
      old_y_q   <= '0;
      old_col_q <= '0;
      drawn_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      new_x_q   <= new_x_d;
      new_y_q   <= new_y_d;
      new_col_q <= new_col_d;
      old_x_q   <= old_x_d;
      old_y_q   <= old_y_d;
      old_col_q <= old_col_d;
      drawn_q   <= drawn_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign oX       = x_q;
  assign oY       = y_q;
  assign oColour  = colour_q;
  assign oPlot    = plot_q;
  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oOverrun = overrun_q;

endmodule
